// File: rtl/gbe_gpu_status_pkg.sv
`default_nettype none
// ============================================================================
// gbe_gpu_status_pkg
// Shared types and status-word bit positions for the GPU 10GbE TX collector.
// Revision: 1.0
// ============================================================================
package gbe_gpu_status_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_IN_FRAME = 2'b01,
    ST_DISCARD  = 2'b10
  } frm_state_e;

  localparam int LINK_BIT   = 31;
  localparam int OVF_BIT    = 30;
  localparam int AFULL_BIT  = 29;
  localparam int LENERR_BIT = 28;
  localparam int STATE_LSB  = 26;
  localparam int FRM_CNT_W  = 20;

  function automatic logic [31:0] pack_status(
    input logic                 link,
    input logic                 ovf,
    input logic                 afull,
    input logic                 len_err,
    input frm_state_e           st,
    input logic [FRM_CNT_W-1:0] cnt
  );
    logic [31:0] w;
    w                      = '0;
    w[LINK_BIT]            = link;
    w[OVF_BIT]             = ovf;
    w[AFULL_BIT]           = afull;
    w[LENERR_BIT]          = len_err;
    w[STATE_LSB +: 2]      = st;
    w[FRM_CNT_W-1:0]       = cnt;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gbe_gpu_status_if.sv
`default_nettype none
// ============================================================================
// gbe_gpu_status_if
// TX-stream monitor inputs and packed status output of the collector.
// Revision: 1.0
// ============================================================================
interface gbe_gpu_status_if;

  logic        tx_valid;
  logic        tx_end_of_frame;
  logic        tx_overflow;
  logic        tx_afull;
  logic        link_up;
  logic        cnt_rst;
  logic [31:0] status_word;

  modport master (
    output tx_valid,
    output tx_end_of_frame,
    output tx_overflow,
    output tx_afull,
    output link_up,
    output cnt_rst,
    input  status_word
  );

  modport slave (
    input  tx_valid,
    input  tx_end_of_frame,
    input  tx_overflow,
    input  tx_afull,
    input  link_up,
    input  cnt_rst,
    output status_word
  );

endinterface
`default_nettype wire

// File: rtl/gbe_gpu_frame_checker.sv
`default_nettype none
// ============================================================================
// gbe_gpu_frame_checker
// Framing FSM: counts beats per frame, flags good frames and length errors.
// Revision: 1.0
// ============================================================================
module gbe_gpu_frame_checker
  import gbe_gpu_status_pkg::*;
#(
  parameter int PKT_WORDS  = 128,
  parameter int BEAT_CNT_W = 16
) (
  input  logic       user_clk,
  input  logic       user_rst,
  input  logic       tx_valid,
  input  logic       tx_end_of_frame,
  output frm_state_e state,
  output logic       good_frame,
  output logic       len_err
);

  localparam logic [BEAT_CNT_W-1:0] C_PKT_WORDS = BEAT_CNT_W'(PKT_WORDS);
  localparam logic [BEAT_CNT_W-1:0] C_ONE       = BEAT_CNT_W'(1);

  frm_state_e            state_q, state_d;
  logic [BEAT_CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [BEAT_CNT_W-1:0] w_beat_inc;
  logic                  w_last;

  assign w_beat_inc = beat_cnt_q + C_ONE;
  assign w_last     = (w_beat_inc == C_PKT_WORDS);

  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      state_q    <= ST_IDLE;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (tx_valid) begin
          if (tx_end_of_frame) begin
            beat_cnt_d = '0;
          end else begin
            state_d    = ST_IN_FRAME;
            beat_cnt_d = C_ONE;
          end
        end
      end
      ST_IN_FRAME: begin
        if (tx_valid) begin
          if (tx_end_of_frame) begin
            state_d    = ST_IDLE;
            beat_cnt_d = '0;
          end else if (w_last) begin
            state_d    = ST_DISCARD;
          end else begin
            beat_cnt_d = w_beat_inc;
          end
        end
      end
      ST_DISCARD: begin
        if (tx_valid && tx_end_of_frame) begin
          state_d    = ST_IDLE;
          beat_cnt_d = '0;
        end
      end
      // Encoding 2'b11 can only come from an upset; recover unconditionally.
      default: begin
        state_d    = ST_IDLE;
        beat_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    good_frame = 1'b0;
    len_err    = 1'b0;
    if (tx_valid) begin
      case (state_q)
        ST_IDLE:     len_err = tx_end_of_frame;
        ST_IN_FRAME: begin
          good_frame = tx_end_of_frame & w_last;
          len_err    = tx_end_of_frame ? ~w_last : w_last;
        end
        default: ;
      endcase
    end
  end

  assign state = state_q;

endmodule
`default_nettype wire

// File: rtl/gbe_gpu_status_collector.sv
`default_nettype none
// ============================================================================
// gbe_gpu_status_collector
// Accumulates 10GbE TX link/overflow/framing health into a registered word.
// Revision: 1.0
// ============================================================================
module gbe_gpu_status_collector
  import gbe_gpu_status_pkg::*;
#(
  parameter int PKT_WORDS  = 128,
  parameter int BEAT_CNT_W = 16
) (
  input  logic              user_clk,
  input  logic              user_rst,
  gbe_gpu_status_if.slave   bus
);

  localparam logic [FRM_CNT_W-1:0] C_FRM_MAX = '1;

  frm_state_e           w_state;
  logic                 w_good;
  logic                 w_len_err;
  logic                 w_clr;

  logic                 cnt_rst_q, cnt_rst_d;
  logic                 link_q, link_d;
  logic                 ovf_q, ovf_d;
  logic                 afull_q, afull_d;
  logic                 len_err_q, len_err_d;
  logic [FRM_CNT_W-1:0] frm_cnt_q, frm_cnt_d;
  logic [31:0]          status_q, status_d;

  gbe_gpu_frame_checker #(
    .PKT_WORDS  (PKT_WORDS),
    .BEAT_CNT_W (BEAT_CNT_W)
  ) u_frame_checker (
    .user_clk        (user_clk),
    .user_rst        (user_rst),
    .tx_valid        (bus.tx_valid),
    .tx_end_of_frame (bus.tx_end_of_frame),
    .state           (w_state),
    .good_frame      (w_good),
    .len_err         (w_len_err)
  );

  // Only the rising edge of the software level clears; holding it is benign.
  assign w_clr = bus.cnt_rst & ~cnt_rst_q;

  always_comb begin
    cnt_rst_d = bus.cnt_rst;
    link_d    = bus.link_up;
    ovf_d     = ovf_q   | bus.tx_overflow;
    afull_d   = afull_q | bus.tx_afull;
    len_err_d = len_err_q | w_len_err;
    frm_cnt_d = frm_cnt_q;
    if (w_good && (frm_cnt_q != C_FRM_MAX)) begin
      frm_cnt_d = frm_cnt_q + FRM_CNT_W'(1);
    end
    if (w_clr) begin
      ovf_d     = 1'b0;
      afull_d   = 1'b0;
      len_err_d = 1'b0;
      frm_cnt_d = '0;
    end
    status_d = pack_status(link_q, ovf_q, afull_q, len_err_q, w_state, frm_cnt_q);
  end

  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      cnt_rst_q <= 1'b0;
      link_q    <= 1'b0;
      ovf_q     <= 1'b0;
      afull_q   <= 1'b0;
      len_err_q <= 1'b0;
      frm_cnt_q <= '0;
      status_q  <= '0;
    end else begin
      cnt_rst_q <= cnt_rst_d;
      link_q    <= link_d;
      ovf_q     <= ovf_d;
      afull_q   <= afull_d;
      len_err_q <= len_err_d;
      frm_cnt_q <= frm_cnt_d;
      status_q  <= status_d;
    end
  end

  assign bus.status_word = status_q;

endmodule
`default_nettype wire
